// File: rtl/uart_ins_loader.sv
// uart_ins_loader
//
// Serial instruction loader for the single-cycle MIPS core. It receives 8N1
// UART bytes on RXD and packs them big-endian into 32-bit instruction words:
// the first byte goes to [31:24] and the fourth byte to [7:0]. Each finished
// word is presented on W_Ins with a one-cycle WE strobe and a word address.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 4)
//   ADDR_W        width of the word address; the index wraps at 2^ADDR_W
//   TIMEOUT_BITS  inter-byte timeout in bit times (used with ISL_TIMEOUT_EN)
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-low reset
//   RXD      in   UART receive line, idle high, asynchronous to CLK
//   LOAD_EN  in   loader enable; when low the loader is held idle and its
//                 progress is cleared
//   W_Ins    out  assembled instruction word
//   WE       out  one-cycle write strobe; W_Ins and WADDR are valid while high
//   WADDR    out  word index of the word being written
//   BUSY     out  high from start-bit detection until a word completes or
//                 its partial bytes are discarded
//   FERR     out  sticky framing-error flag
//   TOUT     out  one-cycle inter-byte timeout pulse
//
// Build option
//   ISL_TIMEOUT_EN  when defined, a partial word (1-3 bytes) that sits idle
//                   for TIMEOUT_BITS bit times is discarded and TOUT pulses.
//                   When undefined, TOUT is tied low and no timeout counter
//                   is built.

module uart_ins_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RXD,
    input  logic              LOAD_EN,
    output logic [31:0]       W_Ins,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic              BUSY,
    output logic              FERR,
    output logic              TOUT
);

    // Reject parameter values that would break the bit timing.
    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("uart_ins_loader: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // RXD synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic rxd_meta_q;
    logic rxd_sync_q;
    logic rxd_prev_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    logic rxd_fall;
    assign rxd_fall = rxd_prev_q & ~rxd_sync_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             byte_ok;
    logic             frame_err;
    logic             start_det;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        rx_byte_d = rx_byte_q;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        start_det = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rxd_fall) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    start_det = 1'b1;
                end
            end
            S_START: begin
                // Recheck mid start bit; a line that is already high again
                // was a glitch and leaves no trace.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    rx_byte_d = {rxd_sync_q, rx_byte_q[7:1]};
                    bit_d     = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Returning to IDLE at the stop-bit midpoint leaves half a
                // bit of margin for a back-to-back start edge.
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rxd_sync_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!LOAD_EN) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            bit_d     = '0;
            byte_ok   = 1'b0;
            frame_err = 1'b0;
            start_det = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            rx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Word assembly and write port
    // ------------------------------------------------------------------
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_sr_q, word_sr_d;
    logic [31:0]       w_ins_q, w_ins_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              ferr_q, ferr_d;
    logic              tout_hit;

`ifdef ISL_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Inter-byte timeout on a partial word
    // ------------------------------------------------------------------
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_M1 = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            tout_q;

    // The counter is held at zero unless the receiver is idle with a partial
    // word pending, so any start-bit detection restarts it.
    always_comb begin
        tcnt_d   = '0;
        tout_hit = 1'b0;
        if (LOAD_EN && (state_q == S_IDLE) && (byte_cnt_q != 2'd0) && !start_det) begin
            if (tcnt_q == TO_M1) begin
                tout_hit = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tcnt_q <= '0;
            tout_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tout_q <= tout_hit;
        end
    end

    assign TOUT = tout_q;
`else
    assign tout_hit = 1'b0;
    assign TOUT     = 1'b0;
`endif

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_sr_d  = word_sr_q;
        w_ins_d    = w_ins_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        ferr_d     = ferr_q;

        // The address advances on the cycle after the strobe so it stays
        // stable for the whole WE cycle.
        if (we_q) begin
            waddr_d = waddr_q + 1'b1;
        end

        if (byte_ok) begin
            if (byte_cnt_q == 2'd3) begin
                w_ins_d    = {word_sr_q, rx_byte_q};
                we_d       = 1'b1;
                byte_cnt_d = 2'd0;
            end else begin
                word_sr_d  = {word_sr_q[15:0], rx_byte_q};
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end

        if (frame_err) begin
            byte_cnt_d = 2'd0;
            ferr_d     = 1'b1;
        end

        if (tout_hit) begin
            byte_cnt_d = 2'd0;
        end

        // A WE already registered is not cancelled; W_Ins keeps its value.
        if (!LOAD_EN) begin
            byte_cnt_d = 2'd0;
            waddr_d    = '0;
            ferr_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            byte_cnt_q <= '0;
            word_sr_q  <= '0;
            w_ins_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            ferr_q     <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_sr_q  <= word_sr_d;
            w_ins_q    <= w_ins_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign W_Ins = w_ins_q;
    assign WE    = we_q;
    assign WADDR = waddr_q;
    assign FERR  = ferr_q;
    assign BUSY  = (state_q != S_IDLE) || (byte_cnt_q != 2'd0);

endmodule

// File: tb/tb_uart_ins_loader.sv
module tb_uart_ins_loader;

    localparam int CPB = 8;
    localparam int AW  = 2;

    logic          CLK     = 1'b0;
    logic          RST     = 1'b0;
    logic          RXD     = 1'b1;
    logic          LOAD_EN = 1'b1;
    logic [31:0]   W_Ins;
    logic          WE;
    logic [AW-1:0] WADDR;
    logic          BUSY;
    logic          FERR;
    logic          TOUT;

    int n_checks = 0;
    int n_fail   = 0;

    uart_ins_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .TIMEOUT_BITS (20)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .RXD     (RXD),
        .LOAD_EN (LOAD_EN),
        .W_Ins   (W_Ins),
        .WE      (WE),
        .WADDR   (WADDR),
        .BUSY    (BUSY),
        .FERR    (FERR),
        .TOUT    (TOUT)
    );

    always #5 CLK = ~CLK;

    // Observed write-port activity, captured mid-cycle.
    logic [31:0] got_word[$];
    int          got_addr[$];
    int          got_next[$];
    int          tout_seen = 0;
    bit          we_prev   = 1'b0;

    // Behavioural model: bytes received so far in the current word, the next
    // word index and the sticky error flag.
    logic [7:0]  part[$];
    logic [31:0] exp_word[$];
    int          exp_addr[$];
    int          m_addr = 0;
    bit          m_ferr = 1'b0;
    logic [31:0] m_last = 32'h0;

    always @(negedge CLK) begin
        if (we_prev) got_next.push_back(int'(WADDR));
        if (WE) begin
            got_word.push_back(W_Ins);
            got_addr.push_back(int'(WADDR));
        end
        if (TOUT) tout_seen++;
        we_prev = WE;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Send one 8N1 frame; 'good' selects a valid or a forced-low stop bit.
    task automatic tx(input logic [7:0] b, input bit good);
        RXD = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            idle(CPB);
        end
        RXD = good;
        idle(CPB);
        RXD = 1'b1;
        if (good) begin
            part.push_back(b);
            if (part.size() == 4) begin
                m_last = {part[0], part[1], part[2], part[3]};
                exp_word.push_back(m_last);
                exp_addr.push_back(m_addr);
                m_addr = (m_addr + 1) % (1 << AW);
                part.delete();
            end
        end else begin
            part.delete();
            m_ferr = 1'b1;
        end
    endtask

    task automatic reload();
        LOAD_EN = 1'b0;
        idle(4);
        LOAD_EN = 1'b1;
        idle(4);
        part.delete();
        m_addr = 0;
        m_ferr = 1'b0;
        exp_word.delete();
        exp_addr.delete();
        got_word.delete();
        got_addr.delete();
        got_next.delete();
        tout_seen = 0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RXD = 1'b1;
        LOAD_EN = 1'b1;
        idle(5);
        n_checks++;
        if ({W_Ins, WE, WADDR, BUSY, FERR, TOUT} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: W_Ins=%h WE=%b WADDR=%0d BUSY=%b FERR=%b TOUT=%b, all required 0",
                     W_Ins, WE, WADDR, BUSY, FERR, TOUT);
        end
        RST = 1'b1;
        idle(1000);
        n_checks++;
        if (got_word.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_we: %0d WE pulses, required 0", got_word.size());
        end
        n_checks++;
        if ({W_Ins, WADDR, BUSY, FERR, TOUT} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: W_Ins=%h WADDR=%0d BUSY=%b FERR=%b TOUT=%b, all required 0",
                     W_Ins, WADDR, BUSY, FERR, TOUT);
        end
    endtask

    task automatic test_single_word();
        reload();
        tx(8'h20, 1'b1);
        tx(8'h08, 1'b1);
        tx(8'h00, 1'b1);
        tx(8'h05, 1'b1);
        idle(24);
        n_checks++;
        if (got_word.size() != 1) begin
            n_fail++;
            $display("FAIL single_we_count: %0d pulses, required 1", got_word.size());
        end else begin
            n_checks++;
            if (got_word[0] !== exp_word[0]) begin
                n_fail++;
                $display("FAIL single_word: W_Ins=%h, required %h", got_word[0], exp_word[0]);
            end
            n_checks++;
            if (got_addr[0] !== exp_addr[0]) begin
                n_fail++;
                $display("FAIL single_addr: WADDR=%0d, required %0d", got_addr[0], exp_addr[0]);
            end
            n_checks++;
            if (got_next.size() != 1 || got_next[0] !== (exp_addr[0] + 1) % (1 << AW)) begin
                n_fail++;
                $display("FAIL single_addr_next: WADDR after WE=%0d, required %0d",
                         (got_next.size() != 0) ? got_next[0] : -1, (exp_addr[0] + 1) % (1 << AW));
            end
        end
    endtask

    task automatic test_back_to_back();
        reload();
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 4; k++) tx(8'($urandom), 1'b1);
        end
        idle(24);
        n_checks++;
        if (got_word.size() != exp_word.size()) begin
            n_fail++;
            $display("FAIL b2b_we_count: %0d pulses, required %0d", got_word.size(), exp_word.size());
        end
        for (int i = 0; i < exp_word.size() && i < got_word.size(); i++) begin
            n_checks++;
            if (got_word[i] !== exp_word[i] || got_addr[i] !== exp_addr[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: W_Ins=%h WADDR=%0d, required %h at %0d",
                         i, got_word[i], got_addr[i], exp_word[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_framing_error();
        reload();
        tx(8'h12, 1'b1);
        tx(8'h34, 1'b0);
        idle(16);
        n_checks++;
        if (FERR !== m_ferr) begin
            n_fail++;
            $display("FAIL ferr_set: FERR=%b, required %b", FERR, m_ferr);
        end
        n_checks++;
        if (got_word.size() != 0 || BUSY !== (part.size() != 0)) begin
            n_fail++;
            $display("FAIL ferr_discard: %0d WE pulses BUSY=%b, required 0 pulses BUSY=%b",
                     got_word.size(), BUSY, part.size() != 0);
        end
        tx(8'hAA, 1'b1);
        tx(8'hBB, 1'b1);
        tx(8'hCC, 1'b1);
        tx(8'hDD, 1'b1);
        idle(24);
        n_checks++;
        if (got_word.size() != 1) begin
            n_fail++;
            $display("FAIL ferr_recover_count: %0d pulses, required 1", got_word.size());
        end else begin
            n_checks++;
            if (got_word[0] !== exp_word[0] || got_addr[0] !== exp_addr[0]) begin
                n_fail++;
                $display("FAIL ferr_recover_word: W_Ins=%h WADDR=%0d, required %h at %0d",
                         got_word[0], got_addr[0], exp_word[0], exp_addr[0]);
            end
        end
        n_checks++;
        if (FERR !== m_ferr) begin
            n_fail++;
            $display("FAIL ferr_sticky: FERR=%b, required %b", FERR, m_ferr);
        end
    endtask

    task automatic test_glitch();
        reload();
        RXD = 1'b0;
        idle(2);
        RXD = 1'b1;
        idle(20);
        n_checks++;
        if (BUSY !== 1'b0 || got_word.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_idle: BUSY=%b WE pulses=%0d, required BUSY=0 and 0 pulses",
                     BUSY, got_word.size());
        end
        for (int k = 0; k < 4; k++) tx(8'($urandom), 1'b1);
        idle(24);
        n_checks++;
        if (got_word.size() != 1 || got_word[0] !== exp_word[0] || got_addr[0] !== exp_addr[0]) begin
            n_fail++;
            $display("FAIL glitch_word: %0d pulses first W_Ins=%h, required 1 pulse with %h at %0d",
                     got_word.size(), (got_word.size() != 0) ? got_word[0] : 32'h0,
                     exp_word[0], exp_addr[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] held;
        reload();
        held = m_last;
        tx(8'($urandom), 1'b1);
        tx(8'($urandom), 1'b1);
        LOAD_EN = 1'b0;
        idle(3);
        n_checks++;
        if (W_Ins !== held || WADDR !== '0 || FERR !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold: W_Ins=%h WADDR=%0d FERR=%b BUSY=%b, required %h 0 0 0",
                     W_Ins, WADDR, FERR, BUSY, held);
        end
        LOAD_EN = 1'b1;
        part.delete();
        m_addr = 0;
        idle(4);
        for (int k = 0; k < 4; k++) tx(8'($urandom), 1'b1);
        idle(24);
        n_checks++;
        if (got_word.size() != 1 || got_word[0] !== exp_word[0] || got_addr[0] !== exp_addr[0]) begin
            n_fail++;
            $display("FAIL abort_word: %0d pulses first W_Ins=%h, required 1 pulse with %h at %0d",
                     got_word.size(), (got_word.size() != 0) ? got_word[0] : 32'h0,
                     exp_word[0], exp_addr[0]);
        end
    endtask

    task automatic test_timeout();
        int exp_tout;
        reload();
        tx(8'($urandom), 1'b1);
        tx(8'($urandom), 1'b1);
        idle(200);
`ifdef ISL_TIMEOUT_EN
        exp_tout = 1;
        part.delete();
`else
        exp_tout = 0;
`endif
        n_checks++;
        if (tout_seen != exp_tout || got_word.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_pulse: TOUT pulses=%0d WE pulses=%0d, required %0d and 0",
                     tout_seen, got_word.size(), exp_tout);
        end
        n_checks++;
        if (BUSY !== (part.size() != 0)) begin
            n_fail++;
            $display("FAIL timeout_busy: BUSY=%b, required %b", BUSY, part.size() != 0);
        end
        for (int k = 0; k < 4; k++) tx(8'($urandom), 1'b1);
        idle(24);
        n_checks++;
        if (got_word.size() != 1 || got_word[0] !== exp_word[0] || got_addr[0] !== exp_addr[0]) begin
            n_fail++;
            $display("FAIL timeout_word: %0d pulses first W_Ins=%h, required 1 pulse with %h at %0d",
                     got_word.size(), (got_word.size() != 0) ? got_word[0] : 32'h0,
                     exp_word[0], exp_addr[0]);
        end
        n_checks++;
        if (tout_seen != exp_tout) begin
            n_fail++;
            $display("FAIL timeout_total: TOUT pulses=%0d, required %0d", tout_seen, exp_tout);
        end
    endtask

    task automatic test_async_reset();
        reload();
        for (int k = 0; k < 6; k++) tx(8'($urandom), 1'b1);
        n_checks++;
        if (WADDR !== AW'(m_addr) || W_Ins !== m_last) begin
            n_fail++;
            $display("FAIL pre_reset_state: WADDR=%0d W_Ins=%h, required %0d %h",
                     WADDR, W_Ins, m_addr, m_last);
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if ({W_Ins, WE, WADDR, BUSY, FERR, TOUT} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: W_Ins=%h WADDR=%0d BUSY=%b FERR=%b, all required 0",
                     W_Ins, WADDR, BUSY, FERR);
        end
        idle(2);
        RST = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_abort();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
